hazard_unit: RTL and testbench
==============================

HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter MULT_LAT, default 4, EX-stage cycles a multiply occupies the mult/div unit (legal 2..63).
REQ-002 Parameter DIV_LAT, default 32, EX-stage cycles a divide occupies the mult/div unit (legal 2..63).
REQ-003 clk  input  1  single clock, all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 Rs_ID, Rt_ID  input  5 each  source registers of the instruction in ID.
REQ-006 writereg_EX, writereg_M  input  5 each  destination registers in EX and MEM.
REQ-007 RegWrite_EX, MemtoReg_EX, MemtoReg_M  input  1 each  writeback controls in EX and MEM.
REQ-008 Branch_ID  input  1  ID holds a beq/bne that compares registers in ID.
REQ-009 PCSrc_ID  input  1  branch taken as resolved in ID.
REQ-010 MulDivUse_ID  input  1  ID holds mult/div/mfhi/mflo.
REQ-011 MulDivStart_EX, MulDivIsDiv_EX  input  1 each  start pulse for mult/div in EX; 1 = divide.
REQ-012 StallF, StallD  output  1 each  hold PC and IF/ID register.
REQ-013 FlushD, FlushE  output  1 each  clear IF/ID and ID/EX registers.
REQ-014 MulDivBusy  output  1  mult/div unit occupied.
REQ-015 MulDivDone  output  1  one-cycle pulse: write HI/LO this cycle.
REQ-016 stall_count  output  16  saturating count of stalled cycles.

Function
REQ-017 lwstall SHALL be 1 when MemtoReg_EX and writereg_EX != 0 and writereg_EX equals Rs_ID or Rt_ID.
REQ-018 branchstall SHALL be 1 when Branch_ID and, for a nonzero matching source, either (RegWrite_EX and writereg_EX matches) or (MemtoReg_M and writereg_M matches).
REQ-019 mdstall SHALL be 1 when MulDivUse_ID and (state != IDLE or MulDivStart_EX).
REQ-020 stall = lwstall | branchstall | mdstall; StallF = StallD = FlushE = stall, combinationally in the same cycle.
REQ-021 FlushD SHALL equal PCSrc_ID & ~stall.
REQ-022 FSM states: IDLE, BUSY, DONE.
REQ-023 In IDLE, MulDivStart_EX SHALL load the counter with (MulDivIsDiv_EX ? DIV_LAT : MULT_LAT) - 2 and go to BUSY.
REQ-024 In BUSY, the counter SHALL decrement each cycle; at counter 0 the FSM SHALL go to DONE.
REQ-025 DONE SHALL last one cycle, then return to IDLE; a MulDivStart_EX asserted in DONE SHALL be taken as in IDLE (DONE -> BUSY).
REQ-026 MulDivStart_EX in BUSY SHALL be ignored (an illegal sequence, prevented by REQ-019).
REQ-027 MulDivBusy = (state == BUSY); MulDivDone = (state == DONE); both are registered-state decodes with no input paths.
REQ-028 Start to MulDivDone latency SHALL be exactly MULT_LAT or DIV_LAT cycles, start cycle counted as cycle 1.
REQ-029 stall_count SHALL increment on each rising edge where stall = 1 and SHALL saturate at 16'hFFFF.
REQ-030 Register 0 SHALL never create a hazard.

Reset
REQ-031 rst_n low SHALL immediately force state IDLE, counter 0, and stall_count 0, so that MulDivBusy = MulDivDone = 0.
REQ-032 Reset mid-operation SHALL abandon the operation with no MulDivDone pulse; StallF/StallD/FlushD/FlushE then follow inputs combinationally.

Structure
REQ-033 The FSM state encoding (IDLE = 2'b00, BUSY = 2'b01, DONE = 2'b10) and default latencies SHALL reside in the shared pipeline package.
REQ-034 Latency counter plus FSM SHALL be one sub-module, muldiv_sequencer; hazard comparators stay in hazard_unit.

Verification
REQ-035 Load-use: MemtoReg_EX = 1, writereg_EX = 8, Rs_ID = 8 -> StallF = StallD = FlushE = 1 and FlushD = 0; with writereg_EX = 0 -> all 0.
REQ-036 Branch hazard: Branch_ID = 1, Rt_ID = 9, RegWrite_EX = 1, writereg_EX = 9, PCSrc_ID = 1 -> stall = 1 and FlushD = 0; next cycle with no match -> FlushD = 1.
REQ-037 Divide: start with MulDivIsDiv_EX = 1 at cycle 1 -> MulDivBusy high for cycles 2..31 and MulDivDone pulses in cycle 32; mfhi in ID from cycle 1 stalls through cycle 32.
REQ-038 Multiply: start at cycle 1 -> MulDivDone in cycle 4; a back-to-back start in the DONE cycle -> BUSY again, with the next MulDivDone in cycle 7.
REQ-039 Reset: rst_n low at cycle 10 of a divide -> MulDivBusy = 0 immediately, no MulDivDone, stall_count = 0.
REQ-040 Saturation: stall held for 70000 cycles -> stall_count = 16'hFFFF and stays there.

Source files
------------

// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Types and constants shared by the pipeline hazard logic:
//   md_state_e        mult/div sequencer state encoding
//   DEFAULT_MULT_LAT  default multiply occupancy in EX cycles
//   DEFAULT_DIV_LAT   default divide occupancy in EX cycles
//   MD_CNT_W          width of the sequencer latency counter (holds up to 61)
//   STALL_CNT_MAX     saturation value of the stall counter
//   reg_match()       register dependency test that never fires for $zero
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_BUSY = 2'b01,
        MD_DONE = 2'b10
    } md_state_e;

    localparam int DEFAULT_MULT_LAT = 4;
    localparam int DEFAULT_DIV_LAT  = 32;
    localparam int MD_CNT_W         = 6;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // A source depends on a destination only when both name the same
    // register and that register is not $zero, which is hardwired to 0.
    function automatic logic reg_match(input logic [4:0] src, input logic [4:0] dst);
        return (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_unit_muldiv_sequencer.sv
// -----------------------------------------------------------------------------
// muldiv_sequencer
// Tracks occupancy of the iterative multiply/divide unit. A start pulse from
// EX launches an operation; the unit reports busy while it iterates and then
// raises done for exactly one cycle, the cycle in which HI/LO are written.
// Start-to-done latency is MULT_LAT or DIV_LAT cycles, counting the start
// cycle as cycle 1. Legal latencies are 2..63.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset (returns to IDLE, no done)
//   start_i   in   start pulse for an operation in EX
//   is_div_i  in   1 = divide, 0 = multiply (qualifies start_i)
//   busy_o    out  state == BUSY (registered decode)
//   done_o    out  state == DONE (registered decode)
//   idle_o    out  state == IDLE (registered decode)
// -----------------------------------------------------------------------------
module muldiv_sequencer
    import hazard_unit_pkg::*;
#(
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic is_div_i,
    output logic busy_o,
    output logic done_o,
    output logic idle_o
);

    // The counter holds the number of BUSY cycles still to run, including
    // the current one. Start and done cycles are not BUSY cycles, so an
    // operation of latency L spends L-2 cycles in BUSY.
    localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_LAT - 2);
    localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_LAT - 2);

    md_state_e             state_q, state_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;
    logic [MD_CNT_W-1:0]   load_val;

    assign load_val = is_div_i ? DIV_LOAD : MULT_LOAD;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            // DONE accepts a new start exactly like IDLE so that back-to-back
            // operations lose no cycle.
            MD_IDLE, MD_DONE: begin
                if (start_i) begin
                    cnt_d   = load_val;
                    // A latency of 2 has no BUSY cycles at all.
                    state_d = (load_val == '0) ? MD_DONE : MD_BUSY;
                end else begin
                    cnt_d   = '0;
                    state_d = MD_IDLE;
                end
            end
            // start_i is ignored here; the ID-stage stall keeps a second
            // operation from reaching EX while the unit is occupied.
            MD_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= MD_CNT_W'(1)) begin
                    state_d = MD_DONE;
                end
            end
            default: begin
                state_d = MD_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_o = (state_q == MD_BUSY);
    assign done_o = (state_q == MD_DONE);
    assign idle_o = (state_q == MD_IDLE);

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Stall/flush control for a 5-stage MIPS-style pipeline with ID-stage branch
// resolution and an iterative multiply/divide unit.
//
// Ports
//   clk             in   rising-edge clock
//   rst_n           in   asynchronous active-low reset
//   Rs_ID, Rt_ID    in   [4:0] source registers of the instruction in ID
//   writereg_EX     in   [4:0] destination register in EX
//   writereg_M      in   [4:0] destination register in MEM
//   RegWrite_EX     in   EX instruction writes the register file
//   MemtoReg_EX     in   EX instruction is a load
//   MemtoReg_M      in   MEM instruction is a load
//   Branch_ID       in   ID holds a register-compare branch
//   PCSrc_ID        in   branch resolved taken in ID
//   MulDivUse_ID    in   ID holds mult/div/mfhi/mflo
//   MulDivStart_EX  in   mult/div start pulse in EX
//   MulDivIsDiv_EX  in   1 = the starting operation is a divide
//   StallF, StallD  out  hold PC and IF/ID register
//   FlushD, FlushE  out  clear IF/ID and ID/EX registers
//   MulDivBusy      out  mult/div unit occupied
//   MulDivDone      out  one-cycle pulse, write HI/LO this cycle
//   stall_count     out  [15:0] saturating count of stalled cycles
// -----------------------------------------------------------------------------
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int MULT_LAT = DEFAULT_MULT_LAT,
    parameter int DIV_LAT  = DEFAULT_DIV_LAT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  Rs_ID,
    input  logic [4:0]  Rt_ID,
    input  logic [4:0]  writereg_EX,
    input  logic [4:0]  writereg_M,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        MemtoReg_M,
    input  logic        Branch_ID,
    input  logic        PCSrc_ID,
    input  logic        MulDivUse_ID,
    input  logic        MulDivStart_EX,
    input  logic        MulDivIsDiv_EX,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        MulDivBusy,
    output logic        MulDivDone,
    output logic [15:0] stall_count
);

    logic        md_idle;
    logic        lwstall;
    logic        branchstall;
    logic        mdstall;
    logic        stall;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    muldiv_sequencer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_muldiv_sequencer (
        .clk      (clk),
        .rst_n    (rst_n),
        .start_i  (MulDivStart_EX),
        .is_div_i (MulDivIsDiv_EX),
        .busy_o   (MulDivBusy),
        .done_o   (MulDivDone),
        .idle_o   (md_idle)
    );

    // Load-use: the load in EX has no data until after MEM, so the consumer
    // in ID must wait one cycle.
    assign lwstall = MemtoReg_EX &&
                     (reg_match(Rs_ID, writereg_EX) || reg_match(Rt_ID, writereg_EX));

    // Branches compare in ID, so any ALU result still in EX, or load data
    // still in MEM, is not yet forwardable to the comparator.
    assign branchstall = Branch_ID && (
                         (RegWrite_EX && (reg_match(Rs_ID, writereg_EX) ||
                                          reg_match(Rt_ID, writereg_EX))) ||
                         (MemtoReg_M  && (reg_match(Rs_ID, writereg_M) ||
                                          reg_match(Rt_ID, writereg_M))));

    // A mult/div/mfhi/mflo in ID waits while the unit is occupied, including
    // the cycle an operation is starting in EX (the sequencer is still IDLE
    // then) and the DONE cycle in which HI/LO are being written.
    assign mdstall = MulDivUse_ID && (!md_idle || MulDivStart_EX);

    assign stall  = lwstall || branchstall || mdstall;
    assign StallF = stall;
    assign StallD = stall;
    assign FlushE = stall;
    // A taken branch squashes the fetched instruction only once the branch
    // itself actually leaves ID.
    assign FlushD = PCSrc_ID && !stall;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && (stall_cnt_q != STALL_CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  Rs_ID, Rt_ID, writereg_EX, writereg_M;
    logic        RegWrite_EX, MemtoReg_EX, MemtoReg_M;
    logic        Branch_ID, PCSrc_ID, MulDivUse_ID;
    logic        MulDivStart_EX, MulDivIsDiv_EX;
    logic        StallF, StallD, FlushD, FlushE;
    logic        MulDivBusy, MulDivDone;
    logic [15:0] stall_count;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_cnt  = 16'd0;
    logic        exp_stall_now = 1'b0;
    logic [8:1]  mul_busy_tbl;
    logic [8:1]  mul_done_tbl;

    always #5 clk = ~clk;

    hazard_unit #(.MULT_LAT(4), .DIV_LAT(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .Rs_ID          (Rs_ID),
        .Rt_ID          (Rt_ID),
        .writereg_EX    (writereg_EX),
        .writereg_M     (writereg_M),
        .RegWrite_EX    (RegWrite_EX),
        .MemtoReg_EX    (MemtoReg_EX),
        .MemtoReg_M     (MemtoReg_M),
        .Branch_ID      (Branch_ID),
        .PCSrc_ID       (PCSrc_ID),
        .MulDivUse_ID   (MulDivUse_ID),
        .MulDivStart_EX (MulDivStart_EX),
        .MulDivIsDiv_EX (MulDivIsDiv_EX),
        .StallF         (StallF),
        .StallD         (StallD),
        .FlushD         (FlushD),
        .FlushE         (FlushE),
        .MulDivBusy     (MulDivBusy),
        .MulDivDone     (MulDivDone),
        .stall_count    (stall_count)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Checks all stall-related outputs for the current cycle and remembers
    // whether the coming edge should bump the stall counter.
    task automatic chk_stall(input string tag, input logic s, input logic fd);
        chk1({tag, ".StallF"}, StallF, s);
        chk1({tag, ".StallD"}, StallD, s);
        chk1({tag, ".FlushE"}, FlushE, s);
        chk1({tag, ".FlushD"}, FlushD, fd);
        exp_stall_now = s;
    endtask

    task automatic next_cycle();
        if (exp_stall_now && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        exp_stall_now = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs_ID = 5'd0; Rt_ID = 5'd0; writereg_EX = 5'd0; writereg_M = 5'd0;
        RegWrite_EX = 1'b0; MemtoReg_EX = 1'b0; MemtoReg_M = 1'b0;
        Branch_ID = 1'b0; PCSrc_ID = 1'b0; MulDivUse_ID = 1'b0;
        MulDivStart_EX = 1'b0; MulDivIsDiv_EX = 1'b0;
    endtask

    initial begin
        // Reset state
        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk1("rst.busy", MulDivBusy, 1'b0);
        chk1("rst.done", MulDivDone, 1'b0);
        chk16("rst.count", stall_count, 16'd0);
        chk_stall("rst", 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_stall_now = 1'b0;
        next_cycle();

        // Load-use on Rs, then on Rt, then register 0
        MemtoReg_EX = 1'b1; writereg_EX = 5'd8; Rs_ID = 5'd8; Rt_ID = 5'd3;
        #1; chk_stall("lw_rs", 1'b1, 1'b0);
        next_cycle();
        Rs_ID = 5'd3; Rt_ID = 5'd8;
        #1; chk_stall("lw_rt", 1'b1, 1'b0);
        next_cycle();
        writereg_EX = 5'd0; Rs_ID = 5'd0; Rt_ID = 5'd0;
        #1; chk_stall("lw_r0", 1'b0, 1'b0);
        next_cycle();
        writereg_EX = 5'd8; Rs_ID = 5'd9; Rt_ID = 5'd10;
        #1; chk_stall("lw_nomatch", 1'b0, 1'b0);
        next_cycle();
        clear_inputs();

        // Branch hazards
        Branch_ID = 1'b1; Rt_ID = 5'd9; Rs_ID = 5'd2; RegWrite_EX = 1'b1;
        writereg_EX = 5'd9; PCSrc_ID = 1'b1;
        #1; chk_stall("br_ex", 1'b1, 1'b0);
        next_cycle();
        writereg_EX = 5'd5;
        #1; chk_stall("br_clear", 1'b0, 1'b1);
        next_cycle();
        PCSrc_ID = 1'b0; MemtoReg_M = 1'b1; writereg_M = 5'd9;
        #1; chk_stall("br_mem", 1'b1, 1'b0);
        next_cycle();
        Branch_ID = 1'b0;
        #1; chk_stall("nobr_mem", 1'b0, 1'b0);
        next_cycle();
        Branch_ID = 1'b1; Rs_ID = 5'd0; Rt_ID = 5'd0; writereg_M = 5'd0;
        writereg_EX = 5'd0;
        #1; chk_stall("br_r0", 1'b0, 1'b0);
        next_cycle();
        clear_inputs();
        #1; chk16("count_after_br", stall_count, 16'd4);

        // Multiply with a back-to-back start in the DONE cycle
        mul_busy_tbl = 8'b0011_0110;
        mul_done_tbl = 8'b0100_1000;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            MulDivStart_EX = (cyc == 1 || cyc == 4);
            MulDivIsDiv_EX = 1'b0;
            #1;
            chk1($sformatf("mul.busy.c%0d", cyc), MulDivBusy, mul_busy_tbl[cyc]);
            chk1($sformatf("mul.done.c%0d", cyc), MulDivDone, mul_done_tbl[cyc]);
            chk1($sformatf("mul.stall.c%0d", cyc), StallF, 1'b0);
            next_cycle();
        end
        clear_inputs();

        // Divide with an mfhi waiting in ID the whole time
        for (int cyc = 1; cyc <= 33; cyc++) begin
            MulDivStart_EX = (cyc == 1);
            MulDivIsDiv_EX = 1'b1;
            MulDivUse_ID   = 1'b1;
            #1;
            chk1($sformatf("div.busy.c%0d", cyc), MulDivBusy, (cyc >= 2 && cyc <= 31));
            chk1($sformatf("div.done.c%0d", cyc), MulDivDone, (cyc == 32));
            chk_stall($sformatf("div.c%0d", cyc), (cyc <= 32), 1'b0);
            next_cycle();
        end
        clear_inputs();
        #1; chk16("count_after_div", stall_count, 16'd36);
        chk16("count_model", stall_count, exp_cnt);

        // Reset in cycle 10 of a divide
        for (int cyc = 1; cyc <= 9; cyc++) begin
            MulDivStart_EX = (cyc == 1);
            MulDivIsDiv_EX = 1'b1;
            next_cycle();
        end
        clear_inputs();
        #1; chk1("div10.busy_before_rst", MulDivBusy, 1'b1);
        rst_n = 1'b0; PCSrc_ID = 1'b1;
        #1;
        chk1("div10.busy_in_rst", MulDivBusy, 1'b0);
        chk1("div10.done_in_rst", MulDivDone, 1'b0);
        chk16("div10.count_in_rst", stall_count, 16'd0);
        chk_stall("div10.rst", 1'b0, 1'b1);
        exp_cnt = 16'd0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1; PCSrc_ID = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            #1;
            chk1($sformatf("post_rst.done.%0d", cyc), MulDivDone, 1'b0);
            chk1($sformatf("post_rst.busy.%0d", cyc), MulDivBusy, 1'b0);
            next_cycle();
        end
        chk16("post_rst.count", stall_count, 16'd0);

        // Saturation of the stall counter
        MemtoReg_EX = 1'b1; writereg_EX = 5'd8; Rs_ID = 5'd8;
        repeat (70000) @(posedge clk);
        #1;
        chk16("sat.count", stall_count, 16'hFFFF);
        chk1("sat.stall", StallF, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk16("sat.hold", stall_count, 16'hFFFF);
        clear_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
